// File: rtl/quad_pkg.sv
// Shared opcodes, response codes, widths and FSM state type for the command decoder.
package quad_pkg;

    localparam int unsigned CMD_W  = 8;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned THR_W  = 9;
    localparam int unsigned RESP_W = 8;

    // Watchdog counter widths: timeout period is 2^width clocks
    localparam int unsigned WD_W_FAST = 9;
    localparam int unsigned WD_W_SLOW = 26;

    localparam logic [CMD_W-1:0] OP_SET_PTCH  = 8'h02;
    localparam logic [CMD_W-1:0] OP_SET_ROLL  = 8'h03;
    localparam logic [CMD_W-1:0] OP_SET_YAW   = 8'h04;
    localparam logic [CMD_W-1:0] OP_SET_THRST = 8'h05;
    localparam logic [CMD_W-1:0] OP_CALIBRATE = 8'h06;
    localparam logic [CMD_W-1:0] OP_EMER_LAND = 8'h07;
    localparam logic [CMD_W-1:0] OP_MTRS_OFF  = 8'h08;

    localparam logic [RESP_W-1:0] RESP_ACK = 8'hA5;
    localparam logic [RESP_W-1:0] RESP_NAK = 8'hEE;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAL_WAIT = 2'd1,
        EMER     = 2'd2
    } state_t;

    // Counter width giving the requested watchdog period
    function automatic int unsigned wd_cnt_w(input bit fast_sim);
        return fast_sim ? WD_W_FAST : WD_W_SLOW;
    endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Link-loss watchdog: free-running counter cleared by kick, flags terminal count.
module cmd_watchdog
    import quad_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic kick,
    output logic timeout
);

    localparam int unsigned CNT_W = wd_cnt_w(FAST_SIM);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on kick, otherwise count up and wrap naturally past all-ones
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (kick) begin
            cnt_d = '0;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Terminal count; a coincident kick takes priority
    assign timeout = (&cnt_q) & ~kick;

endmodule

// File: rtl/cmd_cfg.sv
// Remote command decoder: applies set-points, calibration and emergency commands.
module cmd_cfg
    import quad_pkg::*;
#(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_rdy,
    input  logic [CMD_W-1:0]         cmd,
    input  logic [DATA_W-1:0]        data,
    output logic                     clr_cmd_rdy,
    output logic [RESP_W-1:0]        resp,
    output logic                     send_resp,
    input  logic                     cal_done,
    output logic                     strt_cal,
    output logic                     inertial_cal,
    output logic signed [DATA_W-1:0] d_ptch,
    output logic signed [DATA_W-1:0] d_roll,
    output logic signed [DATA_W-1:0] d_yaw,
    output logic [THR_W-1:0]         thrst,
    output logic                     motors_off
);

    state_t state_q;
    logic   accept_c;
    logic   wd_timeout;

    // A packet is consumed only in IDLE; the cycle after an ack the wrapper
    // has not yet dropped cmd_rdy, so that stale level is ignored.
    assign accept_c = (state_q == IDLE) && cmd_rdy && !clr_cmd_rdy;

    cmd_watchdog #(
        .FAST_SIM (FAST_SIM)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .kick    (accept_c),
        .timeout (wd_timeout)
    );

    // Command FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clr_cmd_rdy  <= 1'b0;
            send_resp    <= 1'b0;
            strt_cal     <= 1'b0;
            resp         <= '0;
            inertial_cal <= 1'b0;
            motors_off   <= 1'b1;
            d_ptch       <= '0;
            d_roll       <= '0;
            d_yaw        <= '0;
            thrst        <= '0;
        end else begin
            clr_cmd_rdy <= 1'b0;
            send_resp   <= 1'b0;
            strt_cal    <= 1'b0;

            // Silent link: drop set-points; never coincides with an accept
            if (wd_timeout) begin
                d_ptch <= '0;
                d_roll <= '0;
                d_yaw  <= '0;
                thrst  <= '0;
            end

            case (state_q)
                IDLE: begin
                    if (accept_c) begin
                        clr_cmd_rdy <= 1'b1;
                        case (cmd)
                            OP_SET_PTCH: begin
                                d_ptch    <= $signed(data);
                                resp      <= RESP_ACK;
                                send_resp <= 1'b1;
                            end
                            OP_SET_ROLL: begin
                                d_roll    <= $signed(data);
                                resp      <= RESP_ACK;
                                send_resp <= 1'b1;
                            end
                            OP_SET_YAW: begin
                                d_yaw     <= $signed(data);
                                resp      <= RESP_ACK;
                                send_resp <= 1'b1;
                            end
                            OP_SET_THRST: begin
                                thrst     <= data[THR_W-1:0];
                                resp      <= RESP_ACK;
                                send_resp <= 1'b1;
                            end
                            OP_CALIBRATE: begin
                                strt_cal     <= 1'b1;
                                motors_off   <= 1'b0;
                                inertial_cal <= 1'b1;
                                state_q      <= CAL_WAIT;
                            end
                            OP_EMER_LAND: begin
                                d_ptch  <= '0;
                                d_roll  <= '0;
                                d_yaw   <= '0;
                                thrst   <= '0;
                                state_q <= EMER;
                            end
                            OP_MTRS_OFF: begin
                                motors_off <= 1'b1;
                                resp       <= RESP_ACK;
                                send_resp  <= 1'b1;
                            end
                            default: begin
                                resp      <= RESP_NAK;
                                send_resp <= 1'b1;
                            end
                        endcase
                    end
                end
                CAL_WAIT: begin
                    if (cal_done) begin
                        inertial_cal <= 1'b0;
                        resp         <= RESP_ACK;
                        send_resp    <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                EMER: begin
                    // Set-points were zeroed on entry; ack one cycle later
                    resp      <= RESP_ACK;
                    send_resp <= 1'b1;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_cfg.sv
// Self-checking bench for cmd_cfg: directed scenarios plus randomized commands.
module tb_cmd_cfg;

    logic               clk = 1'b0;
    logic               rst;
    logic               cmd_rdy;
    logic [7:0]         cmd;
    logic [15:0]        data;
    logic               cal_done;
    logic               clr_cmd_rdy;
    logic [7:0]         resp;
    logic               send_resp;
    logic               strt_cal;
    logic               inertial_cal;
    logic signed [15:0] d_ptch;
    logic signed [15:0] d_roll;
    logic signed [15:0] d_yaw;
    logic [8:0]         thrst;
    logic               motors_off;

    int checks   = 0;
    int failures = 0;

    // Reference state of the remote-visible registers
    logic [15:0] m_ptch;
    logic [15:0] m_roll;
    logic [15:0] m_yaw;
    logic [8:0]  m_thrst;
    logic        m_off;
    logic [7:0]  m_resp;

    always #5 clk = ~clk;

    cmd_cfg #(
        .FAST_SIM (1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_rdy      (cmd_rdy),
        .cmd          (cmd),
        .data         (data),
        .clr_cmd_rdy  (clr_cmd_rdy),
        .resp         (resp),
        .send_resp    (send_resp),
        .cal_done     (cal_done),
        .strt_cal     (strt_cal),
        .inertial_cal (inertial_cal),
        .d_ptch       (d_ptch),
        .d_roll       (d_roll),
        .d_yaw        (d_yaw),
        .thrst        (thrst),
        .motors_off   (motors_off)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        m_ptch  = '0;
        m_roll  = '0;
        m_yaw   = '0;
        m_thrst = '0;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".ptch"},  32'($unsigned(d_ptch)), 32'(m_ptch));
        chk({tag, ".roll"},  32'($unsigned(d_roll)), 32'(m_roll));
        chk({tag, ".yaw"},   32'($unsigned(d_yaw)),  32'(m_yaw));
        chk({tag, ".thrst"}, 32'(thrst),             32'(m_thrst));
        chk({tag, ".moff"},  32'(motors_off),        32'(m_off));
    endtask

    // Present one packet in IDLE; returns at N+1 for calibrate, otherwise once the ack is done
    task automatic do_cmd(input logic [7:0] op, input logic [15:0] d);
        logic known;
        cmd     = op;
        data    = d;
        cmd_rdy = 1'b1;
        tick();
        chk("clr_pulse", 32'(clr_cmd_rdy), 32'd1);
        cmd_rdy = 1'b0;
        known   = (op >= 8'h02 && op <= 8'h08);
        case (op)
            8'h02: m_ptch  = d;
            8'h03: m_roll  = d;
            8'h04: m_yaw   = d;
            8'h05: m_thrst = d[8:0];
            8'h06: m_off   = 1'b0;
            8'h07: model_zero();
            8'h08: m_off   = 1'b1;
            default: ;
        endcase
        check_regs("cmd_n1");
        if (op == 8'h06) begin
            chk("cal_strt", 32'(strt_cal), 32'd1);
            chk("cal_inert", 32'(inertial_cal), 32'd1);
            chk("cal_noresp", 32'(send_resp), 32'd0);
            return;
        end
        if (op == 8'h07) begin
            chk("emer_n1_noresp", 32'(send_resp), 32'd0);
            tick();
            chk("emer_ack", 32'(send_resp), 32'd1);
            chk("emer_resp", 32'(resp), 32'hA5);
            chk("emer_noclr", 32'(clr_cmd_rdy), 32'd0);
            m_resp = 8'hA5;
        end else begin
            m_resp = known ? 8'hA5 : 8'hEE;
            chk("ack_pulse", 32'(send_resp), 32'd1);
            chk("ack_resp", 32'(resp), 32'(m_resp));
        end
        tick();
        chk("clr_once", 32'(clr_cmd_rdy), 32'd0);
        chk("ack_once", 32'(send_resp), 32'd0);
        chk("resp_hold", 32'(resp), 32'(m_resp));
        check_regs("cmd_after");
    endtask

    // Entered at the first CAL_WAIT cycle; cal_done stays low for low_cycles cycles
    task automatic run_cal(input int low_cycles);
        int hi;
        hi = 1;
        if (low_cycles == 0) begin
            cal_done = 1'b1;
        end else begin
            cal_done = 1'b0;
            for (int i = 0; i < low_cycles; i++) begin
                tick();
                if (i == low_cycles - 1) cal_done = 1'b1;
                if (inertial_cal) hi++;
                if (strt_cal || send_resp || clr_cmd_rdy) chk("cal_quiet", 32'd1, 32'd0);
            end
        end
        tick();
        cal_done = 1'b0;
        chk("cal_len", 32'(hi), 32'(low_cycles + 1));
        chk("cal_drop", 32'(inertial_cal), 32'd0);
        chk("cal_ack", 32'(send_resp), 32'd1);
        chk("cal_resp", 32'(resp), 32'hA5);
        m_resp = 8'hA5;
        tick();
        chk("cal_ack_once", 32'(send_resp), 32'd0);
        check_regs("cal_after");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [7:0]  op;
        logic [15:0] d;
        int          r;
        bit          sr_seen;

        rst      = 1'b1;
        cmd_rdy  = 1'b0;
        cmd      = '0;
        data     = '0;
        cal_done = 1'b0;
        model_zero();
        m_off  = 1'b1;
        m_resp = 8'h00;
        repeat (3) tick();
        check_regs("reset");
        chk("rst_resp", 32'(resp), 32'h00);
        chk("rst_send", 32'(send_resp), 32'd0);
        chk("rst_clr", 32'(clr_cmd_rdy), 32'd0);
        chk("rst_strt", 32'(strt_cal), 32'd0);
        chk("rst_inert", 32'(inertial_cal), 32'd0);
        rst = 1'b0;
        tick();

        // Pitch write right after reset; motors stay off
        do_cmd(8'h02, 16'h0076);

        // Calibration with cal_done held low 50 cycles
        do_cmd(8'h06, 16'h0000);
        run_cal(50);

        // Thrust truncation, roll, emergency, motors off
        do_cmd(8'h05, 16'h01FF);
        do_cmd(8'h03, 16'hFF03);
        do_cmd(8'h07, 16'h1234);
        do_cmd(8'h08, 16'h0000);

        // Unknown opcode
        do_cmd(8'h09, 16'hBEEF);

        // Calibration already complete on entry
        do_cmd(8'h06, 16'h0000);
        run_cal(0);

        // Packet arriving during calibration waits until IDLE
        do_cmd(8'h06, 16'h0000);
        cmd     = 8'h02;
        data    = 16'h1234;
        cmd_rdy = 1'b1;
        repeat (5) begin
            tick();
            chk("pend_noclr", 32'(clr_cmd_rdy), 32'd0);
            chk("pend_ptch", 32'($unsigned(d_ptch)), 32'(m_ptch));
        end
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        chk("pend_cal_ack", 32'(send_resp), 32'd1);
        chk("pend_cal_noclr", 32'(clr_cmd_rdy), 32'd0);
        chk("pend_cal_inert", 32'(inertial_cal), 32'd0);
        tick();
        m_ptch = 16'h1234;
        chk("pend_clr", 32'(clr_cmd_rdy), 32'd1);
        chk("pend_ack", 32'(send_resp), 32'd1);
        check_regs("pend");
        cmd_rdy = 1'b0;
        tick();
        chk("pend_clr_once", 32'(clr_cmd_rdy), 32'd0);

        // Watchdog: 512 silent cycles after acceptance zero the set-points
        do_cmd(8'h05, 16'h00FF);
        sr_seen = 1'b0;
        repeat (510) begin
            tick();
            sr_seen = sr_seen | send_resp;
        end
        chk("wd_pre_thrst", 32'(thrst), 32'h0FF);
        tick();
        sr_seen = sr_seen | send_resp;
        model_zero();
        check_regs("wd_fire");
        chk("wd_noresp", 32'(sr_seen), 32'd0);

        // Watchdog: command on the terminal cycle wins
        do_cmd(8'h05, 16'h00FF);
        repeat (510) tick();
        cmd     = 8'h02;
        data    = 16'h0BEE;
        cmd_rdy = 1'b1;
        tick();
        cmd_rdy = 1'b0;
        m_ptch  = 16'h0BEE;
        chk("wd_race_clr", 32'(clr_cmd_rdy), 32'd1);
        check_regs("wd_race");
        repeat (20) tick();
        check_regs("wd_race_hold");

        // Randomized command stream
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r <= 7) op = 8'(r + 2);
            else if (r == 8) op = 8'($urandom_range(0, 1));
            else op = 8'($urandom_range(9, 255));
            d = 16'($urandom);
            do_cmd(op, d);
            if (op == 8'h06) run_cal(int'($urandom_range(0, 20)));
            repeat ($urandom_range(0, 4)) tick();
            chk("rnd_resp_hold", 32'(resp), 32'(m_resp));
        end
        check_regs("rnd_end");

        // Asynchronous reset during calibration
        do_cmd(8'h06, 16'h0000);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_inert", 32'(inertial_cal), 32'd0);
        chk("arst_moff", 32'(motors_off), 32'd1);
        model_zero();
        m_off  = 1'b1;
        m_resp = 8'h00;
        tick();
        tick();
        rst = 1'b0;
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        chk("arst_noresp", 32'(send_resp), 32'd0);
        chk("arst_resp", 32'(resp), 32'h00);
        check_regs("arst");
        do_cmd(8'h04, 16'h8001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cmd_cfg.md
CMD_CFG -- requirements
Module: cmd_cfg

Interface
REQ-001 FAST_SIM, default 1, when 1 the watchdog timeout is 2^9 clocks, otherwise 2^26 clocks.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_rdy  input  1  a complete command/data packet from the UART wrapper is valid.
REQ-005 cmd  input  8  command opcode.
REQ-006 data  input  16  payload for the command.
REQ-007 clr_cmd_rdy  output  1  one-cycle pulse acknowledging consumption of the packet.
REQ-008 resp  output  8  response byte to the remote.
REQ-009 send_resp  output  1  one-cycle pulse launching resp.
REQ-010 cal_done  input  1  inertial calibration complete, from the flight-control side.
REQ-011 strt_cal  output  1  one-cycle pulse starting calibration.
REQ-012 inertial_cal  output  1  high while calibration is in progress.
REQ-013 d_ptch, d_roll, d_yaw  output  16 each  signed desired pitch, roll and yaw.
REQ-014 thrst  output  9  unsigned desired thrust.
REQ-015 motors_off  output  1  ESC outputs are forced off while this is high.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, CAL_WAIT and EMER.
- IDLE samples cmd_rdy.
- CAL_WAIT waits for cal_done.
- EMER is a single cycle that zeroes the setpoints.
REQ-017 In IDLE, cmd_rdy high at cycle N SHALL produce clr_cmd_rdy high at cycle N+1 (one cycle only).
REQ-018 Opcode 0x02, 0x03 or 0x04 SHALL load data into d_ptch, d_roll or d_yaw respectively at N+1, with send_resp high and resp=0xA5 at N+1.
REQ-019 Opcode 0x05 SHALL load data[8:0] into thrst at N+1 and discard data[15:9], then ack with 0xA5.
REQ-020 Opcode 0x06 SHALL do the following at N+1:
- pulse strt_cal;
- clear motors_off;
- raise inertial_cal;
- enter CAL_WAIT.
REQ-021 In CAL_WAIT, cal_done high at cycle M SHALL do the following at M+1:
- drop inertial_cal;
- pulse send_resp with resp=0xA5;
- return to IDLE.
REQ-022 Opcode 0x07 SHALL enter EMER and zero d_ptch, d_roll, d_yaw and thrst at N+1, then ack 0xA5 at N+2; motors_off SHALL be unchanged.
REQ-023 Opcode 0x08 SHALL set motors_off at N+1 and ack 0xA5.
- motors_off stays set until the next 0x06.
- Set-point writes while motors_off is set still update the registers.
REQ-024 Any other opcode SHALL leave all registers unchanged and respond resp=0xEE with send_resp at N+1.
REQ-025 cmd_rdy arriving while in CAL_WAIT or EMER SHALL NOT be cleared; it is serviced on the first IDLE cycle afterwards.
REQ-026 resp SHALL hold its last value between send_resp pulses.
REQ-027 The watchdog counter SHALL reset to 0 on every cycle clr_cmd_rdy is high and SHALL otherwise increment.
REQ-028 On reaching the terminal count, the watchdog SHALL perform the same zeroing as 0x07, without a response, and wrap to 0.
REQ-029 If the watchdog terminal count coincides with an accepted command, the command SHALL win and the counter SHALL reset.
REQ-030 If cal_done is already high when CAL_WAIT is entered, CAL_WAIT SHALL complete on that cycle.

Reset
REQ-031 Reset SHALL take effect immediately and independently of clk.
REQ-032 Reset SHALL put the block in the following state:
- FSM in IDLE, watchdog counter 0;
- d_ptch, d_roll, d_yaw and thrst all 0;
- motors_off=1, inertial_cal=0;
- strt_cal, send_resp and clr_cmd_rdy all 0;
- resp=0x00.
REQ-033 Reset asserted mid-calibration SHALL abort the calibration, with inertial_cal=0 and no response.

Structure
REQ-034 Opcode constants 0x02-0x08, the response codes 0xA5 and 0xEE, and the state enum SHALL reside in shared package quad_pkg.
REQ-035 The watchdog SHALL be a sub-module, cmd_watchdog, with ports clk, rst, kick and timeout and parameter FAST_SIM.
REQ-036 Implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-037 Reset, then 0x02/0x0076 -> d_ptch=0x0076, resp=0xA5, clr_cmd_rdy one cycle, motors_off still 1.
REQ-038 0x06, hold cal_done low 50 cycles, then pulse it -> strt_cal one pulse, inertial_cal high 51 cycles, motors_off=0, ack one cycle after cal_done.
REQ-039 0x05/0x01FF then 0x03/0xFF03 -> thrst=0x1FF, d_roll=0xFF03.
- Follow with 0x07 -> all four setpoints 0 and ack at N+2.
- Follow with 0x08 -> motors_off=1.
REQ-040 Set thrst=0x0FF, then send no commands for 512 cycles with FAST_SIM=1 -> thrst=0 with no send_resp.
- Repeat with a command at cycle 511 -> thrst is retained.
REQ-041 Opcode 0x09 -> resp=0xEE and no register change; cmd_rdy raised during CAL_WAIT -> not cleared until after cal_done.
REQ-042 rst pulsed during CAL_WAIT -> inertial_cal=0 asynchronously and motors_off=1.
